// File: rtl/mem_access_ctrl.sv
// MEM-stage data-SRAM access sequencer: grant/rvalid handshake, pipeline stall request,
// store lane replication with byte enables, load extraction/extension, and timeout.
module mem_access_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_gnt,
  input  logic        data_sram_rvalid,
  input  logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int unsigned CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_aerr;
  logic          r_berr;

  logic          w_misalign;
  logic          w_busy;
  logic          w_complete;
  logic          w_load_done;
  logic          w_timeout;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  logic [3:0]    w_wen;
  logic [31:0]   w_wdata;

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = (req_addr[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  // A load finishes on rvalid either in the grant cycle or in WAIT; a store finishes on grant.
  assign w_busy      = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_load_done = ((r_state == S_REQ) && data_sram_gnt && !r_we && data_sram_rvalid) ||
                       ((r_state == S_WAIT) && data_sram_rvalid);
  assign w_complete  = w_load_done || ((r_state == S_REQ) && data_sram_gnt && r_we);
  assign w_timeout   = w_busy && (r_cnt == CW'(WAIT_LIMIT - 1));

  assign w_byte = data_sram_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

  always_comb begin
    w_ext = data_sram_rdata;
    case (r_size)
      2'b00:   w_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = data_sram_rdata;
    endcase
  end

  always_comb begin
    w_wen   = 4'b0000;
    w_wdata = r_wdata;
    case (r_size)
      2'b00: begin
        w_wen   = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_wen   = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      2'b10:   w_wen = 4'b1111;
      default: w_wen = 4'b0000;
    endcase
    if (!r_we) w_wen = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_misalign ? S_DONE : S_REQ;
      S_REQ: begin
        if (w_complete || w_timeout) w_next = S_DONE;
        else if (data_sram_gnt)      w_next = S_WAIT;
      end
      S_WAIT: if (w_complete || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_aerr     <= 1'b0;
      r_berr     <= 1'b0;
    end else if ((r_state == S_IDLE) && req_valid) begin
      r_cnt      <= '0;
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_rdata    <= '0;
      r_aerr     <= w_misalign;
      r_berr     <= 1'b0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_load_done)    r_rdata <= w_ext;
      else if (w_timeout && !w_complete) r_berr <= 1'b1;
    end
  end

  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    stallreq        = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    addr_err        = 1'b0;
    bus_err         = 1'b0;
    case (r_state)
      S_IDLE: stallreq = req_valid && rst;
      S_REQ: begin
        data_sram_en    = 1'b1;
        data_sram_wen   = w_wen;
        data_sram_addr  = {r_addr[31:2], 2'b00};
        data_sram_wdata = w_wdata;
        stallreq        = 1'b1;
      end
      S_WAIT: stallreq = 1'b1;
      S_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        addr_err   = r_aerr;
        bus_err    = r_berr;
      end
      default: stallreq = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a transaction-level model predicts per-cycle
// SRAM strobes, stall and response from the access rules and handshake timing.
module tb_mem_access_ctrl;

  localparam int WL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_gnt;
  logic        data_sram_rvalid;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int txn_id  = 0;

  mem_access_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_gnt(data_sram_gnt), .data_sram_rvalid(data_sram_rvalid),
    .data_sram_rdata(data_sram_rdata),
    .stallreq(stallreq), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d, t=%0t): got %h expected %h", tag, txn_id, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] ad);
    int nb;
    logic [31:0] v;
    logic [31:0] mask;
    nb = 1 << sz;
    if (nb == 4) return rd;
    v    = rd >> (8 * int'(ad[1:0]));
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid        = 1'b0;
    req_we           = 1'($urandom);
    req_size         = 2'($urandom);
    req_unsigned     = 1'($urandom);
    req_addr         = $urandom;
    req_wdata        = $urandom;
    data_sram_gnt    = 1'b0;
    data_sram_rvalid = 1'b0;
    data_sram_rdata  = $urandom;
  endtask

  // g: REQ cycles without grant before the grant; r: cycles from grant to rvalid (-1 = never).
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                         input int g, input int r);
    int nb, nc, n, gc, rc;
    logic mis, to;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_wen;
    txn_id++;
    nb  = 1 << sz;
    mis = (sz == 2'b11) || ((int'(ad[1:0]) % nb) != 0);
    gc  = g + 1;
    rc  = (r < 0) ? 1000000 : gc + r;
    nc  = we ? gc : rc;
    to  = 1'b0;
    if (mis)          n = 0;
    else if (nc > WL) begin n = WL; to = 1'b1; end
    else              n = nc;
    exp_rd  = (mis || to || we) ? 32'd0 : model_load(rd, sz, uns, ad);
    exp_wen = we ? 4'(((1 << nb) - 1) << ad[1:0]) : 4'b0000;
    exp_wd  = '0;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % 4 % ((nb > 4) ? 4 : nb)) +: 8];

    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = ad; req_wdata = wd;
      end else begin
        req_valid = 1'($urandom);
        if (c < gc) begin
          data_sram_rvalid = 1'($urandom);
        end else if (c == gc) begin
          data_sram_gnt    = 1'b1;
          data_sram_rvalid = (rc == c);
        end else begin
          data_sram_gnt    = 1'($urandom);
          data_sram_rvalid = (rc == c);
        end
        if (rc == c) data_sram_rdata = rd;
      end
      #1;
      if (c == 0) begin
        chk("stall_idle", 32'(stallreq), 32'd1);
        chk("en_idle", 32'(data_sram_en), 32'd0);
        chk("resp_idle", 32'(resp_valid), 32'd0);
      end else if (c <= n) begin
        chk("stall_busy", 32'(stallreq), 32'd1);
        chk("resp_busy", 32'(resp_valid), 32'd0);
        chk("en", 32'(data_sram_en), 32'(c <= gc));
        if (c <= gc) begin
          chk("wen", 32'(data_sram_wen), 32'(exp_wen));
          chk("addr", data_sram_addr, {ad[31:2], 2'b00});
          if (we) chk("wdata", data_sram_wdata, exp_wd);
        end
      end else begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("stall_done", 32'(stallreq), 32'd0);
        chk("en_done", 32'(data_sram_en), 32'd0);
        chk("addr_err", 32'(addr_err), 32'(mis));
        chk("bus_err", 32'(bus_err), 32'(to));
        chk("rdata", resp_rdata, exp_rd);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("resp_after", 32'(resp_valid), 32'd0);
    chk("stall_after", 32'(stallreq), 32'd0);
  endtask

  initial begin
    logic [1:0] sz;
    int g, r, sel;
    rst = 1'b1;
    idle_inputs();
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_en", 32'(data_sram_en), 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 1);   // lb
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 1);   // lbu
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 2, 0);   // sh
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h1234_5678, 0, 0);   // misaligned lw
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, -1);  // timeout
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 15);  // rvalid on last cycle
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h1234_5678, 0, 0);   // lh same-cycle
    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hA5A5_5A5A, 32'h0, 15, 0);  // store granted last cycle
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_0077, 32'h0, 16, 0);  // store grant too late

    // Reset while waiting for rvalid, then confirm a clean idle.
    @(negedge clk);
    idle_inputs();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h100;
    @(negedge clk);
    idle_inputs(); data_sram_gnt = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wait_stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_en", 32'(data_sram_en), 32'd0);
    chk("rst_mid_stall", 32'(stallreq), 32'd0);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      data_sram_rvalid = 1'b1;
      data_sram_gnt    = 1'b1;
      #1;
      chk("post_rst_resp", 32'(resp_valid), 32'd0);
      chk("post_rst_en", 32'(data_sram_en), 32'd0);
      chk("post_rst_stall", 32'(stallreq), 32'd0);
    end
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0, 0);

    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      sz  = (sel == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      g   = (sel == 1) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
      if (sel == 2)      r = -1;
      else if (sel == 3) r = int'($urandom_range(10, 16));
      else               r = int'($urandom_range(0, 3));
      run_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom, g, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
